conv3x3_stream_filter: RTL and testbench

// - Streaming 3x3 neighbourhood filter for the camera pixel path.
// - Sits after the Bayer-to-grayscale stage and before the VGA/SDRAM writer.
// - Builds the 3x3 window from two inferred line buffers.
// - Applies a run-time selectable kernel: pass-through, Sobel-X, Sobel-Y or |Gx|+|Gy|.
// - Emits one output per input pixel, with fixed latency and border zeroing.

---
 rtl/conv3x3_stream_filter.sv | 178 +++++++++++++++++
 tb/tb_conv3x3_stream_filter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream_filter.sv
// Streaming 3x3 filter (pass, |Gx|, |Gy|, |Gx|+|Gy|) using two line buffers.
// Fixed 3-cycle latency from iDVAL to oDVAL. Stages always advance.
// No backpressure: every accepted pixel produces one oDVAL pulse, and gaps travel through as bubbles.
module conv3x3_stream_filter #(
    parameter int PIX_W = 12,
    parameter int IMG_W = 1280,
    parameter int SHIFT = 2
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSOF,
    input  logic [1:0]       iMODE,
    input  logic [PIX_W-1:0] iDATA,
    input  logic             iDVAL,
    output logic [PIX_W-1:0] oDATA,
    output logic             oDVAL,
    output logic [1:0]       oMODE
);
    localparam int CW = $clog2(IMG_W);
    localparam int SW = PIX_W + 4;
    localparam logic [SW-1:0] SAT_MAX = {4'b0000, {PIX_W{1'b1}}};

    // S1 state: position counters, latched mode, window
    logic [CW-1:0]    r_col;
    logic [1:0]       r_row;
    logic [1:0]       r_mode;
    logic [PIX_W-1:0] r_lb1 [0:IMG_W-1];
    logic [PIX_W-1:0] r_lb2 [0:IMG_W-1];
    logic [PIX_W-1:0] r_win [0:2][0:2];
    logic             r_s1_vld;
    logic             r_s1_border;
    logic [1:0]       r_s1_mode;

    // S2 state: signed gradients plus the pass-through centre
    logic signed [SW-1:0] r_gx;
    logic signed [SW-1:0] r_gy;
    logic [PIX_W-1:0]     r_s2_ctr;
    logic                 r_s2_vld;
    logic                 r_s2_border;
    logic [1:0]           r_s2_mode;

    // S3 state: output registers
    logic [PIX_W-1:0] r_odata;
    logic             r_odval;

    // A start of frame only counts when it comes with a valid pixel.
    logic             w_sof;
    logic [CW-1:0]    w_col;
    logic [1:0]       w_row;
    logic [1:0]       w_mode;
    logic [PIX_W-1:0] w_lb1_rd;
    logic [PIX_W-1:0] w_lb2_rd;
    logic             w_last_col;

    assign w_sof      = iSOF & iDVAL;
    assign w_col      = w_sof ? '0 : r_col;
    assign w_row      = w_sof ? 2'd0 : r_row;
    assign w_mode     = w_sof ? iMODE : r_mode;
    assign w_lb1_rd   = r_lb1[w_col];
    assign w_lb2_rd   = r_lb2[w_col];
    assign w_last_col = (w_col == CW'(IMG_W - 1));

    // S1: advance the counters, latch the mode at frame start and shift the window left
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_col       <= '0;
            r_row       <= '0;
            r_mode      <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_mode   <= '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else begin
            r_s1_vld <= iDVAL;
            if (iDVAL) begin
                r_mode      <= w_mode;
                r_s1_mode   <= w_mode;
                // The window reaches two pixels back, so the first two rows and columns are incomplete.
                r_s1_border <= (w_col < CW'(2)) || (w_row < 2'd2);
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_lb2_rd;
                r_win[1][2] <= w_lb1_rd;
                r_win[2][2] <= iDATA;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
            end
        end
    end

    // Line buffers are left uncleared by reset; border zeroing hides any stale contents.
    always_ff @(posedge iCLK) begin
        if (iDVAL && !iRST) begin
            r_lb2[w_col] <= w_lb1_rd;
            r_lb1[w_col] <= iDATA;
        end
    end

    // Sobel partial sums. Row 0 is the oldest line, and column 0 is the leftmost column.
    logic [SW-1:0] w_px, w_nx, w_py, w_ny;
    assign w_px = SW'(r_win[0][2]) + (SW'(r_win[1][2]) << 1) + SW'(r_win[2][2]);
    assign w_nx = SW'(r_win[0][0]) + (SW'(r_win[1][0]) << 1) + SW'(r_win[2][0]);
    assign w_py = SW'(r_win[2][0]) + (SW'(r_win[2][1]) << 1) + SW'(r_win[2][2]);
    assign w_ny = SW'(r_win[0][0]) + (SW'(r_win[0][1]) << 1) + SW'(r_win[0][2]);

    // S2: register the gradients and the sideband that travels with them
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_gx        <= '0;
            r_gy        <= '0;
            r_s2_ctr    <= '0;
            r_s2_vld    <= 1'b0;
            r_s2_border <= 1'b0;
            r_s2_mode   <= '0;
        end else begin
            r_gx        <= w_px - w_nx;
            r_gy        <= w_py - w_ny;
            r_s2_ctr    <= r_win[1][1];
            r_s2_vld    <= r_s1_vld;
            r_s2_border <= r_s1_border;
            r_s2_mode   <= r_s1_mode;
        end
    end

    // |Gx|+|Gy| is at most 8*(2^PIX_W-1), so the sum fits in SW bits.
    logic [SW-1:0]    w_abs_x, w_abs_y, w_mag, w_shifted;
    logic [PIX_W-1:0] w_sat;
    logic [PIX_W-1:0] w_res;
    assign w_abs_x   = r_gx[SW-1] ? -r_gx : r_gx;
    assign w_abs_y   = r_gy[SW-1] ? -r_gy : r_gy;
    assign w_shifted = w_mag >> SHIFT;
    assign w_sat     = (w_shifted > SAT_MAX) ? {PIX_W{1'b1}} : w_shifted[PIX_W-1:0];

    // Select the magnitude for the mode that the pixel was accepted with
    always_comb begin
        w_mag = '0;
        case (r_s2_mode)
            2'd1:    w_mag = w_abs_x;
            2'd2:    w_mag = w_abs_y;
            2'd3:    w_mag = w_abs_x + w_abs_y;
            default: w_mag = '0;
        endcase
    end

    // Final value: zero on the border, the raw centre in pass mode, otherwise the saturated magnitude
    always_comb begin
        w_res = '0;
        if (!r_s2_border) begin
            w_res = (r_s2_mode == 2'd0) ? r_s2_ctr : w_sat;
        end
    end

    // S3: output register. oDATA is held at zero during bubbles.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_odata <= '0;
            r_odval <= 1'b0;
        end else begin
            r_odval <= r_s2_vld;
            r_odata <= r_s2_vld ? w_res : '0;
        end
    end

    assign oDATA = r_odata;
    assign oDVAL = r_odval;
    assign oMODE = r_mode;
endmodule

// File: tb/tb_conv3x3_stream_filter.sv
module tb_conv3x3_stream_filter;
    localparam int PIX_W = 12;
    localparam int IMG_W = 8;
    localparam int SHIFT = 0;
    localparam int NV    = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             sof;
    logic [1:0]       mode;
    logic [PIX_W-1:0] data;
    logic             dval;
    logic [PIX_W-1:0] o_data;
    logic             o_dval;
    logic [1:0]       o_mode;

    conv3x3_stream_filter #(.PIX_W(PIX_W), .IMG_W(IMG_W), .SHIFT(SHIFT)) dut (
        .iCLK(clk), .iRST(rst), .iSOF(sof), .iMODE(mode), .iDATA(data), .iDVAL(dval),
        .oDATA(o_data), .oDVAL(o_dval), .oMODE(o_mode)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PIX_W-1:0] d;
        int               c;
    } exp_t;

    // pat: 0 = flat 100, 1 = 16*col ramp, 2 = left half 0 / right half 4095
    typedef struct {
        int mode; int pat; int gap; int npix;
        int p1; int e1; int p2; int e2;
    } vec_t;

    exp_t             sb[$];
    int               checks   = 0;
    int               failures = 0;
    int               out_cnt  = 0;
    logic [PIX_W-1:0] out_img [0:511];
    int               img [0:3][0:IMG_W-1];
    vec_t             vecs [0:NV-1];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int pix(input int pat, input int c);
        case (pat)
            0:       return 100;
            1:       return 16 * c;
            default: return (c < IMG_W / 2) ? 0 : 4095;
        endcase
    endfunction

    // Reference 3x3 filter evaluated directly on the stored frame
    function automatic logic [PIX_W-1:0] model(input int m, input int r, input int c);
        int a [0:2][0:2];
        int gx, gy, ax, ay, mag;
        if (c < 2 || r < 2) return '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                a[i][j] = img[r-2+i][c-2+j];
        if (m == 0) return PIX_W'(a[1][1]);
        gx  = (a[0][2] + 2*a[1][2] + a[2][2]) - (a[0][0] + 2*a[1][0] + a[2][0]);
        gy  = (a[2][0] + 2*a[2][1] + a[2][2]) - (a[0][0] + 2*a[0][1] + a[0][2]);
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        mag = (m == 1) ? ax : (m == 2) ? ay : ax + ay;
        mag = mag >>> SHIFT;
        if (mag > 4095) mag = 4095;
        return PIX_W'(mag);
    endfunction

    // Output monitor: pops the scoreboard and checks both the data and the 3-cycle latency
    always @(negedge clk) begin
        exp_t e;
        if (o_dval) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0d required=none", o_data);
            end else begin
                e = sb.pop_front();
                check($sformatf("odata_%0d", out_cnt), int'(o_data), int'(e.d));
                check($sformatf("latency_%0d", out_cnt), cyc, e.c + 3);
            end
            out_img[out_cnt[8:0]] = o_data;
            out_cnt++;
        end
    end

    // Drive one frame. iMODE is changed after the first pixel, and iSOF is pulsed during gaps; the DUT must ignore both.
    task automatic run_frame(input vec_t v, input bit tail_idle);
        for (int p = 0; p < v.npix; p++) begin
            int r, c;
            exp_t e;
            r = p / IMG_W;
            c = p % IMG_W;
            img[r][c] = pix(v.pat, c);
            @(negedge clk);
            dval = 1'b1;
            sof  = (p == 0);
            mode = (p == 0) ? 2'(v.mode) : 2'(v.mode) ^ 2'b11;
            data = PIX_W'(img[r][c]);
            e.d  = model(v.mode, r, c);
            e.c  = cyc;
            sb.push_back(e);
            for (int g = 1; g < v.gap; g++) begin
                @(negedge clk);
                dval = 1'b0;
                sof  = 1'b1;
                data = PIX_W'($urandom);
            end
        end
        if (tail_idle) begin
            @(negedge clk);
            dval = 1'b0;
            sof  = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("%s_drain_left", tag), sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int pend, base_pend, b, tot;
        //            mode pat gap npix  p1  e1    p2 e2
        vecs[0] = '{0,   0,  1,  32,   20, 100,  9, 0};   // flat, pass: border pattern
        vecs[1] = '{1,   1,  1,  32,   27, 128,  8, 0};   // ramp |Gx|; iMODE goes to 2 mid-frame
        vecs[2] = '{2,   1,  1,  32,   27, 0,    30, 0};  // same ramp, |Gy|
        vecs[3] = '{3,   2,  1,  32,   20, 4095, 30, 0};  // step edge saturates, flat is 0
        vecs[4] = '{1,   1,  3,  32,   29, 128,  24, 0};  // gapped ramp
        vecs[5] = '{3,   2,  1,  11,   10, 0,    1, 0};   // cut short by a mid-line iSOF
        vecs[6] = '{3,   1,  1,  32,   30, 128,  25, 0};  // restarted frame, stale buffers hidden

        rst  = 1'b1;
        sof  = 1'b0;
        dval = 1'b0;
        mode = 2'd0;
        data = '0;
        repeat (2) @(negedge clk);
        check("reset_odval", int'(o_dval), 0);
        check("reset_odata", int'(o_data), 0);
        check("reset_omode", int'(o_mode), 0);
        rst = 1'b0;

        pend      = 0;
        base_pend = 0;
        for (int i = 0; i < NV; i++) begin
            if (i == pend) base_pend = out_cnt;
            run_frame(vecs[i], 1'b1);
            if (vecs[i].npix == IMG_W * 4) begin
                drain($sformatf("v%0d", i));
                b   = base_pend;
                tot = 0;
                for (int k = pend; k <= i; k++) begin
                    check($sformatf("v%0d_probe1", k), int'(out_img[b + vecs[k].p1]), vecs[k].e1);
                    check($sformatf("v%0d_probe2", k), int'(out_img[b + vecs[k].p2]), vecs[k].e2);
                    b   += vecs[k].npix;
                    tot += vecs[k].npix;
                end
                check($sformatf("v%0d_count", i), out_cnt - base_pend, tot);
                check($sformatf("v%0d_omode", i), int'(o_mode), vecs[i].mode);
                pend = i + 1;
            end
        end

        // Reset arrives with pixel 20: pixels 18 and 19 are in flight and must be dropped
        base_pend = out_cnt;
        run_frame('{0, 0, 1, 20, 0, 0, 0, 0}, 1'b0);
        @(negedge clk);
        rst  = 1'b1;
        dval = 1'b1;
        sof  = 1'b0;
        data = PIX_W'(100);
        @(negedge clk);
        rst  = 1'b0;
        dval = 1'b0;
        check("midrst_odval", int'(o_dval), 0);
        check("midrst_odata", int'(o_data), 0);
        check("midrst_omode", int'(o_mode), 0);
        check("midrst_count", out_cnt - base_pend, 18);
        sb.delete();
        repeat (2) @(negedge clk);

        base_pend = out_cnt;
        run_frame(vecs[0], 1'b1);
        drain("post_rst");
        check("post_rst_count", out_cnt - base_pend, 32);
        check("post_rst_centre", int'(out_img[base_pend + 20]), 100);
        check("post_rst_border", int'(out_img[base_pend + 9]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
